// File: rtl/blk_a21a8d.sv
// Two-port read-request arbiter: round-robin AR grant into one downstream port,
// with an order FIFO steering returning R beats back to the requester that owns them.
module blk_a21a8d #(
  parameter int BUS_ADDR_WIDTH       = 32,
  parameter int BUS_DATA_WIDTH       = 32,
  parameter int NUM_READ_OUTSTANDING = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          ACLK_EN,
  input  logic [BUS_ADDR_WIDTH-1:0]     in_P0_ARADDR,
  input  logic [31:0]                   in_P0_ARLEN,
  input  logic                          in_P0_ARVALID,
  output logic                          out_P0_ARREADY,
  input  logic [BUS_ADDR_WIDTH-1:0]     in_P1_ARADDR,
  input  logic [31:0]                   in_P1_ARLEN,
  input  logic                          in_P1_ARVALID,
  output logic                          out_P1_ARREADY,
  output logic [BUS_DATA_WIDTH-1:0]     out_P0_RDATA,
  output logic [1:0]                    out_P0_RLAST,
  output logic                          out_P0_RVALID,
  input  logic                          in_P0_RREADY,
  output logic [BUS_DATA_WIDTH-1:0]     out_P1_RDATA,
  output logic [1:0]                    out_P1_RLAST,
  output logic                          out_P1_RVALID,
  input  logic                          in_P1_RREADY,
  output logic [BUS_ADDR_WIDTH-1:0]     out_HLS_ARADDR,
  output logic [31:0]                   out_HLS_ARLEN,
  output logic                          out_HLS_ARVALID,
  input  logic                          in_HLS_ARREADY,
  input  logic [BUS_DATA_WIDTH-1:0]     in_HLS_RDATA,
  input  logic [1:0]                    in_HLS_RLAST,
  input  logic                          in_HLS_RVALID,
  output logic                          out_HLS_RREADY,
  output logic                          out_HLS_RBUST_READY,
  output logic [$clog2(NUM_READ_OUTSTANDING):0] out_ost_count,
  output logic                          dbg_state
);

  localparam int PW = $clog2(NUM_READ_OUTSTANDING);
  localparam logic [PW:0]   FULL_COUNT = NUM_READ_OUTSTANDING[PW:0];
  localparam logic [PW:0]   CNT_ONE    = 1;
  localparam logic [PW-1:0] PTR_ONE    = 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic                            last_grant_q;
  logic [PW-1:0]                   wr_ptr_q, rd_ptr_q;
  logic [PW:0]                     count_q;
  logic [NUM_READ_OUTSTANDING-1:0] order_q;

  logic fifo_full, fifo_empty, head;
  logic grant, grant_port, pop;

  // Handshake semantics: a transfer happens on a cycle where valid and ready are
  // both high; valid never waits on ready, and the source holds its payload stable
  // until that cycle. Full/empty come from registered occupancy only.
  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign head       = order_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_port = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_full && (in_P0_ARVALID || in_P1_ARVALID)) begin
          grant      = 1'b1;
          // On a tie the port that lost last time wins.
          grant_port = (in_P0_ARVALID && in_P1_ARVALID) ? ~last_grant_q : in_P1_ARVALID;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (in_HLS_ARREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_P0_ARREADY  = grant & ~grant_port;
  assign out_P1_ARREADY  = grant & grant_port;
  assign out_HLS_ARVALID = (state_q == ISSUE);
  assign dbg_state       = state_q;

  assign out_HLS_RREADY = !fifo_empty && (head ? in_P1_RREADY : in_P0_RREADY);
  assign out_P0_RVALID  = !fifo_empty && !head && in_HLS_RVALID;
  assign out_P1_RVALID  = !fifo_empty && head && in_HLS_RVALID;
  assign out_P0_RDATA   = in_HLS_RDATA;
  assign out_P1_RDATA   = in_HLS_RDATA;
  assign out_P0_RLAST   = in_HLS_RLAST;
  assign out_P1_RLAST   = in_HLS_RLAST;
  assign out_HLS_RBUST_READY = 1'b1;
  assign out_ost_count  = count_q;

  // Only the request-end beat retires an order entry.
  assign pop = in_HLS_RVALID && out_HLS_RREADY && in_HLS_RLAST[0];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      order_q        <= '0;
      out_HLS_ARADDR <= '0;
      out_HLS_ARLEN  <= '0;
    end else if (ACLK_EN) begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q      <= grant_port;
        out_HLS_ARADDR    <= grant_port ? in_P1_ARADDR : in_P0_ARADDR;
        out_HLS_ARLEN     <= grant_port ? in_P1_ARLEN : in_P0_ARLEN;
        order_q[wr_ptr_q] <= grant_port;
        wr_ptr_q          <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({grant, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_a21a8d.sv
// Bench for blk_a21a8d: arbitration order, R routing by order FIFO, full stall,
// downstream AR stall, stray data, clock enable and mid-operation reset.
module tb_blk_a21a8d;

  logic        clk, rst, en;
  logic [31:0] p0_araddr, p0_arlen, p1_araddr, p1_arlen;
  logic        p0_arvalid, p0_arready, p1_arvalid, p1_arready;
  logic [31:0] p0_rdata, p1_rdata;
  logic [1:0]  p0_rlast, p1_rlast;
  logic        p0_rvalid, p1_rvalid, p0_rready, p1_rready;
  logic [31:0] hls_araddr, hls_arlen;
  logic        hls_arvalid, hls_arready;
  logic [31:0] hls_rdata;
  logic [1:0]  hls_rlast;
  logic        hls_rvalid, hls_rready, hls_rbust_ready;
  logic [1:0]  ost_count;
  logic        dbg_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [0:0]  exp_port_q[$];

  blk_a21a8d #(.BUS_ADDR_WIDTH(32), .BUS_DATA_WIDTH(32), .NUM_READ_OUTSTANDING(2)) dut (
    .ACLK(clk), .ARESET(rst), .ACLK_EN(en),
    .in_P0_ARADDR(p0_araddr), .in_P0_ARLEN(p0_arlen), .in_P0_ARVALID(p0_arvalid), .out_P0_ARREADY(p0_arready),
    .in_P1_ARADDR(p1_araddr), .in_P1_ARLEN(p1_arlen), .in_P1_ARVALID(p1_arvalid), .out_P1_ARREADY(p1_arready),
    .out_P0_RDATA(p0_rdata), .out_P0_RLAST(p0_rlast), .out_P0_RVALID(p0_rvalid), .in_P0_RREADY(p0_rready),
    .out_P1_RDATA(p1_rdata), .out_P1_RLAST(p1_rlast), .out_P1_RVALID(p1_rvalid), .in_P1_RREADY(p1_rready),
    .out_HLS_ARADDR(hls_araddr), .out_HLS_ARLEN(hls_arlen), .out_HLS_ARVALID(hls_arvalid), .in_HLS_ARREADY(hls_arready),
    .in_HLS_RDATA(hls_rdata), .in_HLS_RLAST(hls_rlast), .in_HLS_RVALID(hls_rvalid), .out_HLS_RREADY(hls_rready),
    .out_HLS_RBUST_READY(hls_rbust_ready), .out_ost_count(ost_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: every task starts and ends 1 time unit after a rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input int port, input logic [31:0] addr, input logic [31:0] len, output bit ok);
    bit rdy;
    ok = 1'b0;
    if (port == 0) begin p0_araddr = addr; p0_arlen = len; p0_arvalid = 1'b1; end
    else begin p1_araddr = addr; p1_arlen = len; p1_arvalid = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy = (port == 0) ? p0_arready : p1_arready;
      tick();
      if (rdy) begin ok = 1'b1; break; end
      #0;
    end
    if (port == 0) p0_arvalid = 1'b0; else p1_arvalid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      hls_rvalid = 1'b1;
      hls_rlast  = 2'b11;
      hls_rdata  = 32'hD000 + i;
      tick();
    end
    hls_rvalid = 1'b0;
    hls_rlast  = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hls_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %0b expected 0", hls_arvalid); end
    checks++; if (hls_araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr: got %0h expected 0", hls_araddr); end
    checks++; if (hls_arlen !== 32'h0) begin failures++; $display("FAIL reset_arlen: got %0h expected 0", hls_arlen); end
    checks++; if (ost_count !== 2'd0) begin failures++; $display("FAIL reset_ost: got %0d expected 0", ost_count); end
    checks++; if (hls_rbust_ready !== 1'b1) begin failures++; $display("FAIL rbust_ready: got %0b expected 1", hls_rbust_ready); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state: got %0b expected 0", dbg_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    int n0, n1, ar_seen, last_cyc;
    bit g0, g1;
    logic [63:0] e;
    logic [0:0]  ep;
    n0 = 0; n1 = 0; ar_seen = 0; last_cyc = -1;
    hls_arready = 1'b1;
    hls_rvalid = 1'b1; hls_rlast = 2'b11; hls_rdata = 32'hBEEF;
    p0_araddr = 32'h1000; p0_arlen = 32'd1; p0_arvalid = 1'b1;
    p1_araddr = 32'h2000; p1_arlen = 32'd2; p1_arvalid = 1'b1;
    exp_q.push_back({32'd1, 32'h1000}); exp_port_q.push_back(1'b0);
    exp_q.push_back({32'd2, 32'h2000}); exp_port_q.push_back(1'b1);
    exp_q.push_back({32'd1, 32'h1010}); exp_port_q.push_back(1'b0);
    exp_q.push_back({32'd2, 32'h2010}); exp_port_q.push_back(1'b1);
    for (int cyc = 0; cyc < 30 && ar_seen < 4; cyc++) begin
      #1;
      g0 = p0_arready; g1 = p1_arready;
      if (g0 || g1) begin
        ep = exp_port_q.pop_front();
        checks++; if (g1 !== ep[0] || (g0 && g1)) begin failures++; $display("FAIL rr_grant_port: got p0=%0b p1=%0b expected port %0d", g0, g1, ep); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 2) begin failures++; $display("FAIL rr_spacing: got %0d cycles expected 2", cyc - last_cyc); end
        end
        last_cyc = cyc;
      end
      if (hls_arvalid && hls_arready) begin
        e = exp_q.pop_front();
        checks++; if ({hls_arlen, hls_araddr} !== e) begin failures++; $display("FAIL rr_ar_payload: got %0h expected %0h", {hls_arlen, hls_araddr}, e); end
        ar_seen++;
      end
      tick();
      if (g0) begin n0++; p0_araddr = 32'h1000 + 32'(n0 * 16); if (n0 == 2) p0_arvalid = 1'b0; end
      if (g1) begin n1++; p1_araddr = 32'h2000 + 32'(n1 * 16); if (n1 == 2) p1_arvalid = 1'b0; end
    end
    hls_rvalid = 1'b0; hls_rlast = 2'b00;
    p0_arvalid = 1'b0; p1_arvalid = 1'b0;
    checks++; if (ar_seen != 4) begin failures++; $display("FAIL rr_timeout: got %0d requests expected 4", ar_seen); end
    checks++; if (ost_count !== 2'd0) begin failures++; $display("FAIL rr_ost_end: got %0d expected 0", ost_count); end
    exp_q.delete(); exp_port_q.delete();
  endtask

  task automatic test_r_routing;
    bit ok0, ok1;
    logic [0:0] ep;
    hls_arready = 1'b1;
    drive_ar(0, 32'h3000, 32'd4, ok0);
    drive_ar(1, 32'h4000, 32'd2, ok1);
    checks++; if (!(ok0 && ok1)) begin failures++; $display("FAIL route_grant_timeout: got %0b%0b expected 11", ok0, ok1); end
    checks++; if (ost_count !== 2'd2) begin failures++; $display("FAIL route_ost_start: got %0d expected 2", ost_count); end
    for (int i = 0; i < 4; i++) exp_port_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) exp_port_q.push_back(1'b1);
    for (int i = 0; i < 6; i++) begin
      hls_rvalid = 1'b1;
      hls_rdata  = 32'hA0 + i;
      hls_rlast  = (i == 3 || i == 5) ? 2'b11 : 2'b00;
      #1;
      ep = exp_port_q.pop_front();
      checks++;
      if (ep == 1'b0 ? !(p0_rvalid && !p1_rvalid && p0_rdata == 32'hA0 + i && p0_rlast == hls_rlast)
                     : !(p1_rvalid && !p0_rvalid && p1_rdata == 32'hA0 + i && p1_rlast == hls_rlast)) begin
        failures++; $display("FAIL route_beat%0d: got p0v=%0b p1v=%0b expected port %0d", i, p0_rvalid, p1_rvalid, ep);
      end
      checks++; if (hls_rready !== 1'b1) begin failures++; $display("FAIL route_rready%0d: got %0b expected 1", i, hls_rready); end
      tick();
      if (i == 3) begin
        checks++; if (ost_count !== 2'd1) begin failures++; $display("FAIL route_ost_mid: got %0d expected 1", ost_count); end
      end
    end
    hls_rvalid = 1'b0; hls_rlast = 2'b00;
    checks++; if (ost_count !== 2'd0) begin failures++; $display("FAIL route_ost_end: got %0d expected 0", ost_count); end
  endtask

  task automatic test_order_full;
    bit ok0, ok1;
    hls_arready = 1'b1;
    drive_ar(0, 32'h5000, 32'd1, ok0);
    drive_ar(1, 32'h6000, 32'd1, ok1);
    checks++; if (!(ok0 && ok1)) begin failures++; $display("FAIL full_grant_timeout: got %0b%0b expected 11", ok0, ok1); end
    p0_araddr = 32'h7000; p0_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (p0_arready !== 1'b0) begin failures++; $display("FAIL full_blocked%0d: got %0b expected 0", i, p0_arready); end
      tick();
    end
    checks++; if (ost_count !== 2'd2) begin failures++; $display("FAIL full_ost: got %0d expected 2", ost_count); end
    hls_rvalid = 1'b1; hls_rlast = 2'b01; hls_rdata = 32'h55;
    #1;
    checks++; if (p0_arready !== 1'b0 || p0_rvalid !== 1'b1 || hls_rready !== 1'b1) begin
      failures++; $display("FAIL full_pop_cycle: got ready=%0b rvalid=%0b rready=%0b expected 0 1 1", p0_arready, p0_rvalid, hls_rready);
    end
    tick();
    hls_rvalid = 1'b0; hls_rlast = 2'b00;
    #1;
    checks++; if (p0_arready !== 1'b1) begin failures++; $display("FAIL full_grant_after_pop: got %0b expected 1", p0_arready); end
    tick();
    p0_arvalid = 1'b0;
    tick();
    drain(2);
    checks++; if (ost_count !== 2'd0) begin failures++; $display("FAIL full_ost_end: got %0d expected 0", ost_count); end
  endtask

  task automatic test_ar_stall;
    bit ok;
    hls_arready = 1'b0;
    p0_araddr = 32'h9000; p0_arlen = 32'd3; p0_arvalid = 1'b1;
    drive_ar(1, 32'h8000, 32'd7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_tie_grant: got %0b expected 1", ok); end
    p0_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (hls_arvalid !== 1'b1 || hls_araddr !== 32'h8000 || hls_arlen !== 32'd7 || p0_arready !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d: got v=%0b a=%0h l=%0d r0=%0b expected 1 8000 7 0", i, hls_arvalid, hls_araddr, hls_arlen, p0_arready);
      end
      tick();
    end
    hls_arready = 1'b1;
    tick();
    #1;
    checks++; if (p0_arready !== 1'b1 || hls_arvalid !== 1'b0) begin failures++; $display("FAIL stall_release: got r0=%0b v=%0b expected 1 0", p0_arready, hls_arvalid); end
    tick();
    p0_arvalid = 1'b0;
    tick();
    drain(2);
    checks++; if (ost_count !== 2'd0) begin failures++; $display("FAIL stall_ost_end: got %0d expected 0", ost_count); end
  endtask

  task automatic test_stray;
    hls_rvalid = 1'b1; hls_rlast = 2'b11; hls_rdata = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (hls_rready !== 1'b0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
        failures++; $display("FAIL stray%0d: got rready=%0b p0v=%0b p1v=%0b expected 0 0 0", i, hls_rready, p0_rvalid, p1_rvalid);
      end
      tick();
    end
    hls_rvalid = 1'b0; hls_rlast = 2'b00;
    checks++; if (ost_count !== 2'd0) begin failures++; $display("FAIL stray_ost: got %0d expected 0", ost_count); end
  endtask

  task automatic test_reset_mid;
    bit ok0, ok1;
    hls_arready = 1'b1;
    drive_ar(0, 32'hA000, 32'd3, ok0);
    drive_ar(1, 32'hB000, 32'd5, ok1);
    hls_arready = 1'b0;
    checks++; if (!(ok0 && ok1) || ost_count !== 2'd2) begin failures++; $display("FAIL rmid_setup: got ok=%0b%0b ost=%0d expected 11 2", ok0, ok1, ost_count); end
    en = 1'b0; hls_arready = 1'b1;
    tick(); tick();
    checks++; if (hls_arvalid !== 1'b1 || hls_araddr !== 32'hB000 || ost_count !== 2'd2) begin
      failures++; $display("FAIL en_hold: got v=%0b a=%0h ost=%0d expected 1 b000 2", hls_arvalid, hls_araddr, ost_count);
    end
    rst = 1'b1;
    #1;
    checks++; if (hls_arvalid !== 1'b0 || hls_araddr !== 32'h0 || hls_arlen !== 32'h0 || ost_count !== 2'd0 || dbg_state !== 1'b0) begin
      failures++; $display("FAIL rmid_async: got v=%0b a=%0h l=%0h ost=%0d st=%0b expected all 0", hls_arvalid, hls_araddr, hls_arlen, ost_count, dbg_state);
    end
    tick();
    en = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin en = ~en; tick(); end
    en = 1'b1;
    checks++; if (hls_arvalid !== 1'b0 || ost_count !== 2'd0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      failures++; $display("FAIL rmid_after: got v=%0b ost=%0d expected 0 0", hls_arvalid, ost_count);
    end
    p0_araddr = 32'hC000; p1_araddr = 32'hD000;
    p0_arvalid = 1'b1; p1_arvalid = 1'b1;
    #1;
    checks++; if (p0_arready !== 1'b1 || p1_arready !== 1'b0) begin
      failures++; $display("FAIL rmid_tie: got r0=%0b r1=%0b expected 1 0", p0_arready, p1_arready);
    end
    tick();
    p0_arvalid = 1'b0; p1_arvalid = 1'b0;
    tick();
    checks++; if (hls_araddr !== 32'hC000) begin failures++; $display("FAIL rmid_tie_addr: got %0h expected c000", hls_araddr); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    p0_araddr = '0; p0_arlen = '0; p0_arvalid = 1'b0;
    p1_araddr = '0; p1_arlen = '0; p1_arvalid = 1'b0;
    p0_rready = 1'b1; p1_rready = 1'b1;
    hls_arready = 1'b0; hls_rdata = '0; hls_rlast = 2'b00; hls_rvalid = 1'b0;
    test_reset();
    test_round_robin();
    test_r_routing();
    test_order_full();
    test_ar_stall();
    test_stray();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
